// File: rtl/gray_display_scan.sv
// gray_display_scan: time-multiplexed Gray/binary hex display driver with frame-coherent snapshots
//   clk_i, rst_i (sync, active-high); enable_i display on; mode_i 0=binary 1=Gray;
//   blank_lz_i live leading-zero blanking; cuenta_i packed 4-bit codes (digit 0 = LSBs);
//   display_o active-low {a..g}; anode_o active-low digit select; frame_o snapshot-load pulse
module gray_display_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic                    mode_i,
   input  logic                    blank_lz_i,
   input  logic [4*NUM_DIGITS-1:0] cuenta_i,
   output logic [6:0]              display_o,
   output logic [NUM_DIGITS-1:0]   anode_o,
   output logic                    frame_o
);
   localparam int CW = $clog2(DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   // a snapshot load on the same cycle as a tick would need DIV < 2
   if (DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_param
      $error("gray_display_scan: DIV must be >= 2 and NUM_DIGITS in 1..8");
   end
   logic [CW-1:0]           div_cnt;
   logic [IW-1:0]           dig_idx;
   logic [4*NUM_DIGITS-1:0] snap;
   logic                    snap_mode;
   logic [3:0]              digs [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zero_from;
   logic [3:0]              cur;
   logic [6:0]              seg;
   logic                    tick, load, blank, show;
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      logic [3:0] g;
      assign g       = snap[4*d +: 4];
      assign digs[d] = snap_mode ? {g[3], ^g[3:2], ^g[3:1], ^g[3:0]} : g;
      // zero_from[d]: this digit and every more significant one are zero
      if (d == NUM_DIGITS - 1) begin : g_top
         assign zero_from[d] = digs[d] == 4'd0;
      end else begin : g_low
         assign zero_from[d] = zero_from[d+1] && digs[d] == 4'd0;
      end
   end
   assign tick  = div_cnt == CW'(DIV - 1);
   assign load  = div_cnt == '0 && dig_idx == '0;
   assign cur   = digs[dig_idx];
   assign blank = blank_lz_i && dig_idx != '0 && zero_from[dig_idx];
   assign show  = enable_i && !blank;
   always_comb begin
      seg = 7'b1111111;
      case (cur)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt   <= '0;
         dig_idx   <= '0;
         snap      <= '0;
         snap_mode <= 1'b0;
         frame_o   <= 1'b0;
         display_o <= 7'h7F;
         anode_o   <= '1;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) dig_idx <= dig_idx == IW'(NUM_DIGITS - 1) ? '0 : dig_idx + 1'b1;
         if (load) begin
            snap      <= cuenta_i;
            snap_mode <= mode_i;
         end
         frame_o   <= load;
         display_o <= show ? seg : 7'h7F;
         anode_o   <= show ? ~(NUM_DIGITS'(1) << dig_idx) : '1;
      end
   end
endmodule

// File: tb/tb_gray_display_scan.sv
// tb_gray_display_scan: self-checking bench for gray_display_scan against a cycle-count reference model
module tb_gray_display_scan;
   localparam int N   = 4;
   localparam int DIV = 4;
   localparam logic [6:0] SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   logic           clk = 0;
   logic           rst = 1;
   logic           enable = 1;
   logic           mode = 0;
   logic           blank_lz = 0;
   logic [4*N-1:0] cuenta = '0;
   logic [6:0]     display;
   logic [N-1:0]   anode;
   logic           frame;
   int             nerr = 0;
   int             nchk = 0;
   int             t = 0;
   logic [4*N-1:0] m_snap = '0;
   logic           m_mode = 0;
   logic [6:0]     e_disp;
   logic [N-1:0]   e_an;
   logic           e_frame;
   gray_display_scan #(.NUM_DIGITS(N), .DIV(DIV)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
      .blank_lz_i(blank_lz), .cuenta_i(cuenta), .display_o(display),
      .anode_o(anode), .frame_o(frame));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask
   function automatic logic [4*N-1:0] to_bin(input logic [4*N-1:0] s, input logic g);
      logic [4*N-1:0] r;
      for (int d = 0; d < N; d++) begin
         logic [3:0] v;
         v = s[4*d +: 4];
         r[4*d +: 4] = g ? v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3) : v;
      end
      return r;
   endfunction
   task automatic step();
      @(posedge clk);
      if (rst) begin
         t = 0; m_snap = '0; m_mode = 0;
         e_disp = 7'h7F; e_an = '1; e_frame = 0;
      end else begin
         int idx;
         logic [4*N-1:0] bw;
         logic blk;
         idx = (t / DIV) % N;
         bw  = to_bin(m_snap, m_mode);
         blk = blank_lz && idx > 0 && (bw >> (4 * idx)) == 0;
         if (enable && !blk) begin
            e_disp = SEG[bw[4*idx +: 4]];
            e_an   = ~(N'(1) << idx);
         end else begin
            e_disp = 7'h7F;
            e_an   = '1;
         end
         e_frame = (t % (DIV * N)) == 0;
         if (e_frame) begin
            m_snap = cuenta;
            m_mode = mode;
         end
         t++;
      end
      #1;
      chk("display", 32'(display), 32'(e_disp));
      chk("anode", 32'(anode), 32'(e_an));
      chk("frame", 32'(frame), 32'(e_frame));
      chk("anode_single", 32'($countones(~anode) <= 1), 32'd1);
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic run_to(input int pos);
      for (int i = 0; i < 64 && (t % (DIV * N)) != pos; i++) step();
   endtask
   initial begin
      cuenta = 16'h1234;
      run(3);
      rst = 0;
      run(2 * DIV * N + 1);
      mode = 1; cuenta = 16'h0F82;
      run(2 * DIV * N);
      mode = 0; blank_lz = 1; cuenta = 16'h0005;
      run(2 * DIV * N);
      cuenta = 16'h0000;
      run(2 * DIV * N);
      blank_lz = 0; cuenta = 16'h1234;
      run(2 * DIV * N);
      run_to(DIV);
      cuenta = 16'h5678;
      run(2 * DIV * N);
      enable = 0;
      run(6);
      enable = 1;
      run_to(2 * DIV + 1);
      rst = 1;
      step();
      rst = 0;
      run(2 * DIV * N);
      for (int i = 0; i < 3000; i++) begin
         cuenta   = 16'($urandom) >> (4 * $urandom_range(0, 4));
         mode     = 1'($urandom_range(0, 1));
         blank_lz = 1'($urandom_range(0, 1));
         enable   = $urandom_range(0, 9) != 0;
         rst      = $urandom_range(0, 199) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
